// File: rtl/cmp_pkg.sv
// Relation encoding and helpers shared by the comparator family.
// Flag triples are ordered {big, equal, small}.
package cmp_pkg;

  typedef enum logic [1:0] {REL_EQ, REL_BIG, REL_SMALL} cmp_rel_e;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} cmp_st_e;

  // Big outranks small; all-zero and equal-only flags seed EQ.
  function automatic cmp_rel_e rel_from_flags(input logic [2:0] flags);
    cmp_rel_e r;
    casez (flags)
      3'b1??:  r = REL_BIG;
      3'b0?1:  r = REL_SMALL;
      default: r = REL_EQ;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] rel_to_flags(input cmp_rel_e rel);
    logic [2:0] f;
    case (rel)
      REL_BIG:   f = 3'b100;
      REL_SMALL: f = 3'b001;
      default:   f = 3'b010;
    endcase
    return f;
  endfunction

  // A differing bit is more significant than anything seen so far, so it decides.
  function automatic cmp_rel_e rel_step(input cmp_rel_e rel, input logic a, input logic b);
    cmp_rel_e r;
    if (a && !b)      r = REL_BIG;
    else if (!a && b) r = REL_SMALL;
    else              r = rel;
    return r;
  endfunction

endpackage

// File: rtl/cmp_serial_lsb_if.sv
// Beat input, cascade flags and result handshake of the serial comparator.
interface cmp_serial_lsb_if;
  logic clr;
  logic in_valid;
  logic in_ready;
  logic in_a;
  logic in_b;
  logic fi_big;
  logic fi_equal;
  logic fi_small;
  logic res_valid;
  logic res_ready;
  logic fo_big;
  logic fo_equal;
  logic fo_small;

  modport master (
    output clr, in_valid, in_a, in_b, fi_big, fi_equal, fi_small, res_ready,
    input  in_ready, res_valid, fo_big, fo_equal, fo_small
  );

  modport slave (
    input  clr, in_valid, in_a, in_b, fi_big, fi_equal, fi_small, res_ready,
    output in_ready, res_valid, fo_big, fo_equal, fo_small
  );
endinterface

// File: rtl/cmp_serial_lsb.sv
// LSB-first bit-serial magnitude comparator with cascade seed and a one-entry
// registered result; a result is loaded on the edge accepting the last beat.
module cmp_serial_lsb
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_serial_lsb_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  cmp_st_e        st;
  cmp_rel_e       rel;
  logic [CW-1:0]  cnt;
  logic           alive;
  logic           res_valid_q;
  logic [2:0]     fo_q;

  logic           accept;
  logic           last;
  cmp_rel_e       base;
  cmp_rel_e       rel_nxt;

  // alive keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = alive && !bus.clr && (!res_valid_q || bus.res_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last         = (cnt == LAST);

  always_comb begin
    base    = (st == ST_IDLE) ? rel_from_flags({bus.fi_big, bus.fi_equal, bus.fi_small}) : rel;
    rel_nxt = rel_step(base, bus.in_a, bus.in_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      rel         <= REL_EQ;
      cnt         <= '0;
      alive       <= 1'b0;
      res_valid_q <= 1'b0;
      fo_q        <= 3'b000;
    end else begin
      alive <= 1'b1;
      if (res_valid_q && bus.res_ready)
        res_valid_q <= 1'b0;
      if (bus.clr) begin
        st  <= ST_IDLE;
        rel <= REL_EQ;
        cnt <= '0;
      end else if (accept) begin
        if (last) begin
          st          <= ST_IDLE;
          rel         <= REL_EQ;
          cnt         <= '0;
          res_valid_q <= 1'b1;
          fo_q        <= rel_to_flags(rel_nxt);
        end else begin
          st  <= ST_SHIFT;
          rel <= rel_nxt;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.fo_big    = fo_q[2];
  assign bus.fo_equal  = fo_q[1];
  assign bus.fo_small  = fo_q[0];

endmodule

// File: tb/tb_cmp_serial_lsb.sv
// Directed scoreboard bench for cmp_serial_lsb (WIDTH=8); flags are {big,equal,small}.
module tb_cmp_serial_lsb;

  localparam logic [2:0] F_BIG = 3'b100;
  localparam logic [2:0] F_EQ  = 3'b010;
  localparam logic [2:0] F_SM  = 3'b001;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [2:0] exp_q[$];

  cmp_serial_lsb_if bus ();

  cmp_serial_lsb #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] fo();
    return {bus.fo_big, bus.fo_equal, bus.fo_small};
  endfunction

  // Later beats drive fi=big so any reseeding after the first beat shows up.
  task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input logic [2:0] fi,
                           input int n);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int t;
      bus.in_valid = 1'b1;
      bus.in_a     = a[i];
      bus.in_b     = b[i];
      {bus.fi_big, bus.fi_equal, bus.fi_small} = (i == 0) ? fi : 3'b100;
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.in_ready;
        tick();
        if (!acc) t++;
        if (t > 60) begin
          checks++;
          errors++;
          $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles", i, t);
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [2:0] fi,
                            input logic [2:0] exp);
    exp_q.push_back(exp);
    send_bits(a, b, fi, 8);
  endtask

  // Monitor: every result handshake pops one expected verdict.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", fo());
      end else begin
        check("result", int'(fo()), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = 1'b0;
    bus.in_b = 1'b0;
    {bus.fi_big, bus.fi_equal, bus.fi_small} = 3'b000;
    bus.res_ready = 1'b1;

    #12;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_fo", int'(fo()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    tick();

    // Equal operands, one-cycle result pulse.
    send_frame(8'h5A, 8'h5A, F_EQ, F_EQ);
    @(negedge clk);
    check("t1_valid_next_cycle", int'(bus.res_valid), 1);
    tick();
    @(negedge clk);
    check("t1_valid_one_cycle", int'(bus.res_valid), 0);
    tick();

    // MSB overrides LSBs.
    send_frame(8'h80, 8'h7F, F_EQ, F_BIG);
    // Seed propagation and priority, plus the all-zero seed.
    send_frame(8'h3C, 8'h3C, F_SM, F_SM);
    send_frame(8'h00, 8'h00, 3'b101, F_BIG);
    send_frame(8'h00, 8'h00, 3'b000, F_EQ);
    repeat (2) tick();

    // Hold: first result stays put and blocks input for 5 cycles.
    bus.res_ready = 1'b0;
    send_frame(8'h0F, 8'hF0, F_EQ, F_SM);
    fork
      send_frame(8'hF0, 8'h0F, F_EQ, F_BIG);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("hold_valid", int'(bus.res_valid), 1);
          check("hold_fo", int'(fo()), int'(F_SM));
          check("hold_in_ready", int'(bus.in_ready), 0);
          tick();
        end
        bus.res_ready = 1'b1;
      end
    join
    repeat (3) tick();

    // Abort a partial frame; the blocked beat in the clr cycle must not count.
    send_bits(8'hFF, 8'h00, F_EQ, 3);
    bus.clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 1'b1;
    bus.in_b = 1'b0;
    @(negedge clk);
    check("clr_in_ready", int'(bus.in_ready), 0);
    tick();
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    send_frame(8'h01, 8'h02, F_EQ, F_SM);
    repeat (2) tick();

    // Async reset mid-frame.
    send_bits(8'hFF, 8'h00, F_EQ, 4);
    bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_rst_in_ready", int'(bus.in_ready), 0);
    check("midframe_rst_valid", int'(bus.res_valid), 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Async reset while a result is pending.
    bus.res_ready = 1'b0;
    send_bits(8'hFF, 8'h00, F_EQ, 8);
    @(negedge clk);
    check("pending_valid", int'(bus.res_valid), 1);
    check("pending_fo", int'(fo()), int'(F_BIG));
    #2;
    rst_n = 1'b0;
    #1;
    check("pending_rst_valid", int'(bus.res_valid), 0);
    check("pending_rst_fo", int'(fo()), 0);
    check("pending_rst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("rerelease_in_ready", int'(bus.in_ready), 1);
    tick();
    send_frame(8'h02, 8'h01, F_SM, F_BIG);
    repeat (4) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
